// File: rtl/cam_chk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cam_chk_pkg: shared types for the CAM transaction checker. Rev 1.0    |
// +----------------------------------------------------------------------+
package cam_chk_pkg;

  localparam int DEF_KEY_W  = 16;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_CNT_W  = 16;
  localparam int IDX_W      = $clog2(DEF_DEPTH);

  typedef enum logic [1:0] {
    TR_RESET   = 2'd0,
    TR_WRITE   = 2'd1,
    TR_READ    = 2'd2,
    TR_ILLEGAL = 2'd3
  } tr_type_e;

  typedef enum logic [1:0] {
    ERR_NONE          = 2'd0,
    ERR_READ_MISMATCH = 2'd1,
    ERR_FALSE_HIT     = 2'd2,
    ERR_ILLEGAL_TYPE  = 2'd3
  } err_kind_e;

  typedef struct packed {
    logic                  valid;
    logic [DEF_KEY_W-1:0]  key;
    logic [DEF_DATA_W-1:0] data;
  } entry_t;

  typedef struct packed {
    err_kind_e             kind;
    logic [DEF_KEY_W-1:0]  key;
    logic [DEF_DATA_W-1:0] exp_data;
    logic [DEF_DATA_W-1:0] dut_data;
    logic [DEF_CNT_W-1:0]  stamp;
  } err_rec_t;

endpackage
`default_nettype wire

// File: rtl/cam_chk_lru.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cam_chk_lru: true-LRU age counters; age DEPTH-1 marks the victim.     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module cam_chk_lru
  import cam_chk_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             touch,
  input  logic [IDX_W-1:0] touch_idx,
  input  logic             clear,
  output logic [IDX_W-1:0] lru_idx
);

  logic [IDX_W-1:0] age [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) age[i] <= IDX_W'(i);
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) age[i] <= IDX_W'(i);
    end else if (touch) begin
      // Ages stay a permutation of 0..DEPTH-1: only younger entries shift up.
      for (int i = 0; i < DEPTH; i++) begin
        if (IDX_W'(i) == touch_idx)
          age[i] <= '0;
        else if (age[i] < age[touch_idx])
          age[i] <= age[i] + IDX_W'(1);
      end
    end
  end

  always_comb begin
    lru_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (age[i] == IDX_W'(DEPTH - 1)) lru_idx = IDX_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/cam_tr_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cam_tr_checker: reference-CAM transaction checker with coverage.      |
// | Rev 1.0. Optional error-log FIFO enabled by CAM_CHK_ERR_LOG_EN.       |
// +----------------------------------------------------------------------+
module cam_tr_checker
  import cam_chk_pkg::*;
#(
  parameter int KEY_W  = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
`ifdef CAM_CHK_ERR_LOG_EN
  , parameter int LOG_DEPTH = 4
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tr_valid,
  input  logic [1:0]        tr_type,
  input  logic [KEY_W-1:0]  tr_key,
  input  logic [DATA_W-1:0] tr_wdata,
  input  logic              dut_valid_o,
  input  logic [DATA_W-1:0] dut_rdata,
  output logic              err_pulse,
  output logic [1:0]        err_kind,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  tr_count,
  output logic [DEPTH-1:0]  hit_cov,
  output logic [DEPTH-1:0]  evict_cov,
  output logic              ww_cov,
  output logic              wr_cov
`ifdef CAM_CHK_ERR_LOG_EN
  , input  logic            log_rd,
  output logic              log_empty,
  output logic [2+KEY_W+2*DATA_W+CNT_W-1:0] log_rec,
  output logic              log_ovf
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  ent_valid;
  logic [KEY_W-1:0]  ent_key  [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];

  tr_type_e          ttype;
  logic              hit, has_free;
  logic [IDX_W-1:0]  hit_idx, free_idx, lru_idx, wr_idx;
  logic              touch, clear, wr_en, evict, err_det;
  err_kind_e         kind_det;
  logic [DATA_W-1:0] exp_data;

  logic              prev_valid;
  tr_type_e          prev_type;
  logic [KEY_W-1:0]  prev_key;
  logic [DATA_W-1:0] prev_wdata;
  logic              ww_det, wr_det;

  assign ttype = tr_type_e'(tr_type);

  // Descending scan so the lowest matching / lowest free index wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_valid[i] && ent_key[i] == tr_key) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!ent_valid[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    touch    = 1'b0;
    clear    = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = hit_idx;
    evict    = 1'b0;
    err_det  = 1'b0;
    kind_det = ERR_NONE;
    exp_data = '0;
    if (tr_valid) begin
      case (ttype)
        TR_RESET: clear = 1'b1;
        TR_WRITE: begin
          wr_en = 1'b1;
          touch = 1'b1;
          if (hit)
            wr_idx = hit_idx;
          else if (has_free)
            wr_idx = free_idx;
          else begin
            wr_idx = lru_idx;
            evict  = 1'b1;
          end
        end
        TR_READ: begin
          if (hit) begin
            touch    = 1'b1;
            exp_data = ent_data[hit_idx];
            if (!dut_valid_o || dut_rdata != ent_data[hit_idx]) begin
              err_det  = 1'b1;
              kind_det = ERR_READ_MISMATCH;
            end
          end else if (dut_valid_o) begin
            err_det  = 1'b1;
            kind_det = ERR_FALSE_HIT;
          end
        end
        default: begin
          err_det  = 1'b1;
          kind_det = ERR_ILLEGAL_TYPE;
        end
      endcase
    end
  end

  assign ww_det = tr_valid && prev_valid && prev_type == TR_WRITE && ttype == TR_WRITE &&
                  prev_key == tr_key && prev_wdata != tr_wdata;
  assign wr_det = tr_valid && prev_valid && prev_type == TR_WRITE && ttype == TR_READ &&
                  prev_key == tr_key;

  cam_chk_lru #(.DEPTH(DEPTH)) u_lru (
    .clk       (clk),
    .rst_n     (rst_n),
    .touch     (touch),
    .touch_idx (wr_en ? wr_idx : hit_idx),
    .clear     (clear),
    .lru_idx   (lru_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_key[i]  <= '0;
        ent_data[i] <= '0;
      end
    end else if (clear) begin
      ent_valid <= '0;
    end else if (wr_en) begin
      ent_valid[wr_idx] <= 1'b1;
      ent_key[wr_idx]   <= tr_key;
      ent_data[wr_idx]  <= tr_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse  <= 1'b0;
      err_kind   <= 2'd0;
      err_count  <= '0;
      tr_count   <= '0;
      hit_cov    <= '0;
      evict_cov  <= '0;
      ww_cov     <= 1'b0;
      wr_cov     <= 1'b0;
      prev_valid <= 1'b0;
      prev_type  <= TR_RESET;
      prev_key   <= '0;
      prev_wdata <= '0;
    end else begin
      err_pulse <= err_det;
      if (err_det) begin
        err_kind <= kind_det;
        if (err_count != '1) err_count <= err_count + CNT_W'(1);
      end
      if (tr_valid && tr_count != '1) tr_count <= tr_count + CNT_W'(1);
      if (ttype == TR_READ && touch) hit_cov[hit_idx] <= 1'b1;
      if (evict) evict_cov[wr_idx] <= 1'b1;
      if (ww_det) ww_cov <= 1'b1;
      if (wr_det) wr_cov <= 1'b1;
      prev_valid <= tr_valid;
      if (tr_valid) begin
        prev_type  <= ttype;
        prev_key   <= tr_key;
        prev_wdata <= tr_wdata;
      end
    end
  end

`ifdef CAM_CHK_ERR_LOG_EN
  localparam int REC_W = 2 + KEY_W + 2 * DATA_W + CNT_W;
  localparam int LP_W  = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
  localparam int LC_W  = $clog2(LOG_DEPTH + 1);

  logic [CNT_W-1:0] stamp;
  logic [REC_W-1:0] log_mem [LOG_DEPTH];
  logic [LP_W-1:0]  log_wp, log_rp;
  logic [LC_W-1:0]  log_cnt;
  logic             log_full, log_push, log_pop;

  function automatic logic [LP_W-1:0] ptr_inc(input logic [LP_W-1:0] p);
    return (p == LP_W'(LOG_DEPTH - 1)) ? '0 : p + LP_W'(1);
  endfunction

  assign log_empty = (log_cnt == '0);
  assign log_full  = (log_cnt == LC_W'(LOG_DEPTH));
  assign log_pop   = log_rd && !log_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign log_push  = err_det && (!log_full || log_pop);
  assign log_rec   = log_mem[log_rp];

  always_ff @(posedge clk) begin
    if (log_push) log_mem[log_wp] <= {kind_det, tr_key, exp_data, dut_rdata, stamp};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stamp   <= '0;
      log_wp  <= '0;
      log_rp  <= '0;
      log_cnt <= '0;
      log_ovf <= 1'b0;
    end else begin
      stamp <= stamp + CNT_W'(1);
      if (log_push) log_wp <= ptr_inc(log_wp);
      if (log_pop)  log_rp <= ptr_inc(log_rp);
      if (log_push && !log_pop)
        log_cnt <= log_cnt + LC_W'(1);
      else if (log_pop && !log_push)
        log_cnt <= log_cnt - LC_W'(1);
      if (err_det && !log_push) log_ovf <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cam_tr_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cam_tr_checker: directed + random bench with recency-list model.   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_cam_tr_checker;

  localparam int KW = 16;
  localparam int DW = 32;
  localparam int D  = 8;
  localparam int CW = 16;
  localparam logic [1:0] T_RST = 2'd0, T_WR = 2'd1, T_RD = 2'd2, T_ILL = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tr_valid = 1'b0;
  logic [1:0]    tr_type = 2'd0;
  logic [KW-1:0] tr_key = '0;
  logic [DW-1:0] tr_wdata = '0;
  logic          dut_valid_o = 1'b0;
  logic [DW-1:0] dut_rdata = '0;
  logic          err_pulse, ww_cov, wr_cov;
  logic [1:0]    err_kind;
  logic [CW-1:0] err_count, tr_count;
  logic [D-1:0]  hit_cov, evict_cov;
`ifdef CAM_CHK_ERR_LOG_EN
  localparam int RW = 2 + KW + 2 * DW + CW;
  logic          log_rd = 1'b0;
  logic          log_empty, log_ovf;
  logic [RW-1:0] log_rec;
  logic [RW-1:0] lq[$];
  logic          m_ovf;
  int unsigned   cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end
`endif

  cam_tr_checker #(.KEY_W(KW), .DATA_W(DW), .DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .tr_valid(tr_valid), .tr_type(tr_type),
    .tr_key(tr_key), .tr_wdata(tr_wdata), .dut_valid_o(dut_valid_o),
    .dut_rdata(dut_rdata), .err_pulse(err_pulse), .err_kind(err_kind),
    .err_count(err_count), .tr_count(tr_count), .hit_cov(hit_cov),
    .evict_cov(evict_cov), .ww_cov(ww_cov), .wr_cov(wr_cov)
`ifdef CAM_CHK_ERR_LOG_EN
    , .log_rd(log_rd), .log_empty(log_empty), .log_rec(log_rec), .log_ovf(log_ovf)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: per-index slots plus a recency list (front = most recent).
  logic          mv [D];
  logic [KW-1:0] mk [D];
  logic [DW-1:0] md [D];
  int            rec[$];
  logic [D-1:0]  m_hit, m_evict;
  logic          m_ww, m_wr, m_pulse;
  logic [1:0]    m_kind;
  logic [CW-1:0] m_ecnt, m_tcnt;
  logic          pv;
  logic [1:0]    pty;
  logic [KW-1:0] pk;
  logic [DW-1:0] pwd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic rec_init();
    rec.delete();
    for (int i = 0; i < D; i++) rec.push_back(i);
  endtask

  task automatic touch(input int idx);
    for (int i = 0; i < rec.size(); i++) if (rec[i] == idx) begin rec.delete(i); break; end
    rec.push_front(idx);
  endtask

  function automatic int find(input logic [KW-1:0] k);
    for (int i = 0; i < D; i++) if (mv[i] && mk[i] == k) return i;
    return -1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < D; i++) begin mv[i] = 0; mk[i] = '0; md[i] = '0; end
    rec_init();
    m_hit = '0; m_evict = '0; m_ww = 0; m_wr = 0; m_pulse = 0; m_kind = 0;
    m_ecnt = '0; m_tcnt = '0; pv = 0; pty = 0; pk = '0; pwd = '0;
`ifdef CAM_CHK_ERR_LOG_EN
    lq.delete(); m_ovf = 0;
`endif
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".err_pulse"}, 64'(err_pulse), 64'(m_pulse));
    chk({tag, ".err_kind"},  64'(err_kind),  64'(m_kind));
    chk({tag, ".err_count"}, 64'(err_count), 64'(m_ecnt));
    chk({tag, ".tr_count"},  64'(tr_count),  64'(m_tcnt));
    chk({tag, ".hit_cov"},   64'(hit_cov),   64'(m_hit));
    chk({tag, ".evict_cov"}, 64'(evict_cov), 64'(m_evict));
    chk({tag, ".ww_cov"},    64'(ww_cov),    64'(m_ww));
    chk({tag, ".wr_cov"},    64'(wr_cov),    64'(m_wr));
`ifdef CAM_CHK_ERR_LOG_EN
    chk({tag, ".log_empty"}, 64'(log_empty), 64'(lq.size() == 0));
    chk({tag, ".log_ovf"},   64'(log_ovf),   64'(m_ovf));
`endif
  endtask

  // Drive one cycle, advance the model, then check after the edge.
  task automatic step(input string tag, input logic v, input logic [1:0] ty, input logic [KW-1:0] k,
                      input logic [DW-1:0] wd, input logic dv, input logic [DW-1:0] rd);
    int idx;
    logic err;
    logic [1:0] kind;
    logic [DW-1:0] expd;
    tr_valid = v; tr_type = ty; tr_key = k; tr_wdata = wd; dut_valid_o = dv; dut_rdata = rd;
    err = 0; kind = 0; expd = '0;
    if (v) begin
      if (m_tcnt != '1) m_tcnt++;
      if (pv && pty == T_WR && ty == T_WR && pk == k && pwd != wd) m_ww = 1;
      if (pv && pty == T_WR && ty == T_RD && pk == k) m_wr = 1;
      case (ty)
        T_RST: begin for (int i = 0; i < D; i++) mv[i] = 0; rec_init(); end
        T_WR: begin
          idx = find(k);
          if (idx < 0) begin
            for (int i = D - 1; i >= 0; i--) if (!mv[i]) idx = i;
            if (idx < 0) begin idx = rec[rec.size() - 1]; m_evict[idx] = 1; end
          end
          mv[idx] = 1; mk[idx] = k; md[idx] = wd; touch(idx);
        end
        T_RD: begin
          idx = find(k);
          if (idx >= 0) begin
            m_hit[idx] = 1; touch(idx); expd = md[idx];
            if (!dv || rd != md[idx]) begin err = 1; kind = 1; end
          end else if (dv) begin err = 1; kind = 2; end
        end
        default: begin err = 1; kind = 3; end
      endcase
      pv = 1; pty = ty; pk = k; pwd = wd;
    end else pv = 0;
    if (err) begin
      m_kind = kind;
      if (m_ecnt != '1) m_ecnt++;
`ifdef CAM_CHK_ERR_LOG_EN
      if (lq.size() < 4) lq.push_back({kind, k, expd, rd, CW'(cyc)});
      else m_ovf = 1;
`endif
    end
    m_pulse = err;
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    check_all(tag);
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    int p, idx;
    logic [1:0] ty;
    logic [KW-1:0] k;
    logic dv;
    logic [DW-1:0] rd;

    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Fill, evict index 0, then a false hit on the evicted key.
    for (int i = 1; i <= 8; i++) step("fill", 1, T_WR, KW'(i), DW'(i * 16), 0, 0);
    step("evict9", 1, T_WR, 16'd9, 32'h90, 0, 0);
    chk("evict_cov_k9", 64'(evict_cov), 64'h01);
    step("false_hit", 1, T_RD, 16'd1, 0, 1, 32'h10);
    chk("false_hit_kind", 64'(err_kind), 64'd2);
    chk("false_hit_cnt", 64'(err_count), 64'd1);

    step("rst_tr", 1, T_RST, 0, 0, 0, 0);
    step("rd_after_rst", 1, T_RD, 16'd2, 0, 0, 0);
    chk("rst_tr_no_err", 64'(err_pulse), 64'd0);

    step("wr5", 1, T_WR, 16'd5, 32'hAA, 0, 0);
    step("rd5", 1, T_RD, 16'd5, 0, 1, 32'hAA);
    chk("wr_cov_set", 64'(wr_cov), 64'd1);
    chk("hit_cov_bit0", 64'(hit_cov[0]), 64'd1);

    step("wr3a", 1, T_WR, 16'd3, 32'd1, 0, 0);
    step("wr3b", 1, T_WR, 16'd3, 32'd2, 0, 0);
    chk("ww_cov_set", 64'(ww_cov), 64'd1);
    step("rd3_bad", 1, T_RD, 16'd3, 0, 1, 32'd1);
    chk("mismatch_kind", 64'(err_kind), 64'd1);
    step("idle", 0, 0, 0, 0, 0, 0);
    chk("pulse_one_cycle", 64'(err_pulse), 64'd0);

    // Error in flight, then asynchronous reset mid-stream.
    step("rd3_bad2", 1, T_RD, 16'd3, 0, 1, 32'd7);
    pulse_reset("async_rst");

    // LRU: index 0 refreshed, so index 1 is the victim.
    for (int i = 0; i < 4; i++) step("lru_fill_a", 1, T_WR, KW'(16'h100 + i), DW'(32'h1000 + i), 0, 0);
    step("lru_rd0", 1, T_RD, 16'h100, 0, 1, 32'h1000);
    for (int i = 4; i < 8; i++) step("lru_fill_b", 1, T_WR, KW'(16'h100 + i), DW'(32'h1000 + i), 0, 0);
    step("lru_evict", 1, T_WR, 16'h200, 32'h2000, 0, 0);
    chk("evict_cov_idx1", 64'(evict_cov), 64'h02);

`ifdef CAM_CHK_ERR_LOG_EN
    pulse_reset("log_rst");
    for (int i = 0; i < 5; i++) step("log_wr", 1, T_WR, KW'(16'h20 + i), DW'(32'h55 + i), 0, 0);
    for (int i = 0; i < 5; i++) step("log_rd_bad", 1, T_RD, KW'(16'h20 + i), 0, 1, DW'(32'hE0 + i));
    chk("log_ovf_set", 64'(log_ovf), 64'd1);
    tr_valid = 0;
    for (int i = 0; i < 4; i++) begin
      logic [RW-1:0] e;
      e = lq.pop_front();
      log_rd = 1'b1;
      chk("log_not_empty", 64'(log_empty), 64'd0);
      chk("log_kind_key", 64'(log_rec[RW-1 -: 2+KW]), 64'(e[RW-1 -: 2+KW]));
      chk("log_exp_data", 64'(log_rec[2*DW+CW-1 -: DW]), 64'(e[2*DW+CW-1 -: DW]));
      chk("log_dut_data", 64'(log_rec[DW+CW-1 -: DW]), 64'(e[DW+CW-1 -: DW]));
      chk("log_stamp", 64'(log_rec[CW-1:0]), 64'(e[CW-1:0]));
      @(posedge clk); #1;
      log_rd = 1'b0;
    end
    chk("log_empty_end", 64'(log_empty), 64'd1);
    pulse_reset("log_rst2");
`endif

    // Random traffic over a small key space to exercise hits and evictions.
    for (int n = 0; n < 400; n++) begin
      p = $urandom_range(0, 99);
      k = KW'($urandom_range(0, 11));
      ty = (p < 10) ? T_RST : (p < 13) ? T_ILL : (p < 55) ? T_WR : T_RD;
      idx = find(k);
      dv = (idx >= 0);
      rd = (idx >= 0) ? md[idx] : DW'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        dv = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) rd = DW'($urandom_range(0, 3));
      end
      step("rand", (p >= 8) ? 1'b1 : 1'b0, ty, k, DW'($urandom_range(0, 3)), dv, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cam_tr_checker.md
Name: cam_tr_checker

Overview:
- Synthesizable, parametrised successor to the grader's transaction scoreboard for the CAM.
- Holds its own reference CAM model with true-LRU replacement and observes DUT transactions on a monitor bus.
- Checks every read against the model and raises registered error pulses and counters.
- Accumulates hit, evict, write-write and write-read coverage in hardware; sits beside the DUT in the bench or on an FPGA build.

Parameters:
- KEY_W, 16, key width in bits.
- DATA_W, 32, data width in bits.
- DEPTH, 8, model entries; power of two, 2..64.
- CNT_W, 16, width of error and transaction counters; saturating.
- LOG_DEPTH, 4, error-log FIFO entries; used only with the optional feature.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tr_valid  in  1  one monitored transaction this cycle.
- tr_type  in  2  0=RESET, 1=WRITE, 2=READ, 3=illegal.
- tr_key  in  KEY_W  transaction key.
- tr_wdata  in  DATA_W  write data.
- dut_valid_o  in  1  DUT read-hit flag, same cycle as tr_valid.
- dut_rdata  in  DATA_W  DUT read data, same cycle as tr_valid.
- err_pulse  out  1  one-cycle pulse, registered.
- err_kind  out  2  0=none, 1=READ_MISMATCH, 2=FALSE_HIT, 3=ILLEGAL_TYPE; held until next error.
- err_count  out  CNT_W  total errors.
- tr_count  out  CNT_W  accepted transactions.
- hit_cov  out  DEPTH  sticky per-index read-hit coverage.
- evict_cov  out  DEPTH  sticky per-index LRU-evict coverage.
- ww_cov  out  1  sticky write-write coverage.
- wr_cov  out  1  sticky write-read coverage.

Behaviour:
- Reset, asynchronous on rst_n low: all outputs 0; all model valid bits 0; LRU ages = index; last-transaction register invalid.
- One transaction per cycle; no backpressure.
- Model update is visible to the next cycle's transaction, so back-to-back transactions on the same key are exact.
- Outputs are registered: latency 1 cycle from the tr_valid edge.
- WRITE, key hit: overwrite data; entry becomes MRU.
- WRITE, key miss with an invalid entry: fill the lowest-index invalid entry; MRU.
- WRITE, key miss with all entries valid: replace the LRU entry; set evict_cov[idx]; MRU.
- READ, hit at idx: set hit_cov[idx]; entry becomes MRU.
  - Error READ_MISMATCH if dut_valid_o=0 or dut_rdata != model data.
- READ, miss: error FALSE_HIT if dut_valid_o=1; LRU unchanged.
- RESET: clear all valid bits and reinitialise LRU ages. Coverage and counters are not cleared.
- tr_type=3: ILLEGAL_TYPE error; model untouched; still counted in tr_count.
- LRU: per-entry age counters of log2(DEPTH) bits.
  - On a touch, entries younger than the touched one increment; the touched entry is set to 0.
  - LRU = entry with age DEPTH-1.
- ww_cov set when the previous cycle had tr_valid with WRITE, the current is WRITE to the same key, and wdata differs.
- wr_cov set when the previous cycle was WRITE and the current is READ to the same key.
- An idle cycle (tr_valid=0) invalidates adjacency.
- err_count and tr_count saturate at all-ones; no wrap.
- rst_n asserted mid-stream: any in-flight registered pulse is dropped.

Optional Feature:
- Macro CAM_CHK_ERR_LOG_EN.
- Defined:
  - Adds a LOG_DEPTH error-record FIFO. Record = {err_kind, key, expected data, dut data, CNT_W-bit cycle stamp}.
  - Adds ports log_rd (in 1), log_empty (out 1), log_rec (out, record width).
  - log_rec shows the head record combinationally; log_rd pops it when log_empty=0.
  - When full, new records are dropped and sticky log_ovf (out 1) is set.
  - Simultaneous push and pop on a full FIFO succeeds.
- Undefined: no FIFO, no extra ports; only err_kind and err_count.

Decomposition:
- Package cam_chk_pkg holds:
  - tr_type_e
  - err_kind_e
  - entry_t {valid, key, data}
  - err_rec_t
  - localparam IDX_W = $clog2(DEPTH)
- Sub-module cam_chk_lru (DEPTH):
  - Inputs: touch, touch_idx, clear.
  - Outputs: lru_idx.
  - Owns the age counters.

Test Plan:
- DEPTH=8: write keys 1..8 with data 0x10..0x80, then write key 9 → evict_cov=0x01; a later read of key 1 with dut_valid_o=1 → FALSE_HIT error → err_kind=2, err_count=1.
- Write key 5 data 0xAA; next cycle read key 5 with dut_rdata 0xAA, valid=1 → no error, wr_cov=1, hit_cov bit 0 set.
- Write key 3 data 1, then key 3 data 2 back-to-back → ww_cov=1; read key 3 with rdata 1 → READ_MISMATCH, err_pulse exactly 1 cycle.
- Fill 4 keys, read key 0 to make it MRU, fill 4 more, write a new key → entry idx 1 evicted (evict_cov=0x02), not idx 0.
- RESET transaction after fills, then read any prior key with dut_valid_o=0 → no error; coverage bits retained. Drop rst_n mid-stream → all outputs 0 immediately.
- With CAM_CHK_ERR_LOG_EN, LOG_DEPTH=4: inject 5 mismatches → log_ovf=1; pop 4 records in order with correct keys and stamps; then log_empty=1.
